piso_ser: RTL
=============

Name: piso_ser

Overview:
Parallel-in serial-out serializer that sits directly downstream of the 4-bit PIPO register. It consumes the registered parallel word over a valid/ready handshake and shifts it out one bit per accepted serial beat. A one-word holding buffer lets the next word be accepted while the current word is shifting, so back-to-back words serialize with no bubble. Serial side has its own valid/ready handshake and a last-bit marker.

Parameters:
WIDTH, 4, parallel word width in bits (>=2).
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
p_in  input  WIDTH  parallel word from the PIPO stage.
p_valid  input  1  p_in holds a word to transfer.
p_ready  output  1  serializer can accept p_in this cycle.
s_out  output  1  current serial bit; 0 when s_valid=0.
s_valid  output  1  s_out is a valid bit.
s_ready  input  1  downstream consumes s_out this cycle.
s_last  output  1  s_out is the final bit of the word (s_valid && bit count = WIDTH-1).

Behaviour:
- Single clock domain. All state updates on posedge clk. rst is synchronous and active-high.
- Internal state: FSM {IDLE, SHIFT}; shift register sh[WIDTH-1:0]; bit counter cnt (clog2(WIDTH) bits); holding buffer hold[WIDTH-1:0] with hold_valid.
- Reset, at the first edge with rst=1:
  - state=IDLE, sh=0, cnt=0, hold=0, hold_valid=0.
  - Outputs afterwards: s_valid=0, s_out=0, s_last=0, p_ready=1.
  - rst has priority over all handshakes. A reset mid-word discards sh and hold; no s_last is emitted for the aborted word.
- Handshakes:
  - Parallel transfer occurs when p_valid && p_ready.
  - Serial beat occurs when s_valid && s_ready.
  - p_ready=1 in IDLE; p_ready=!hold_valid in SHIFT.
  - s_valid=1 exactly when state=SHIFT.
- IDLE:
  - On a parallel transfer: sh<=p_in, cnt<=0, state<=SHIFT.
  - Latency: the first bit is on s_out in the cycle after the accept edge.
- SHIFT:
  - s_out = sh[WIDTH-1] if MSB_FIRST, else sh[0].
  - No serial beat: sh and cnt hold; s_out stable (backpressure).
  - Beat with cnt<WIDTH-1: shift sh toward the output end (zero-fill), cnt<=cnt+1.
  - Beat with cnt=WIDTH-1 (last bit), evaluated in priority order:
    (a) hold_valid=1: sh<=hold, hold_valid<=0, cnt<=0, stay SHIFT.
    (b) else a parallel transfer occurs the same cycle: sh<=p_in (bypass hold), cnt<=0, stay SHIFT.
    (c) else state<=IDLE.
  - A parallel transfer in SHIFT not consumed by (b): hold<=p_in, hold_valid<=1.
  - Simultaneous (a) with a new transfer is impossible, since p_ready=0 while hold_valid=1.
- Throughput: continuous p_valid and s_ready give an unbroken s_valid stream, WIDTH bits per word.
- Ordering: words are emitted in accept order. Nothing is ever dropped or duplicated.
- p_in is sampled only on transfer edges; changes at other times have no effect.

Test Plan:
1. Reset: rst=1 for 2 cycles with p_valid=1, p_in=4'hF -> s_valid=0, s_out=0, s_last=0, p_ready=1; nothing is serialized.
2. Single word, WIDTH=4, MSB_FIRST=1, p_in=4'b1011, s_ready=1 -> s_out=1,0,1,1 on the 4 cycles after accept; s_last=1 only on the 4th; s_valid=0 on the 5th.
3. Back-to-back: p_valid held with 4'hA then 4'h5, s_ready=1 -> 8 contiguous bits 1,0,1,0,0,1,0,1 with no gap; s_last on bits 4 and 8; p_ready=0 while hold is full.
4. Backpressure: 4'hC, s_ready=0 for 3 cycles after the 2nd bit -> s_out=1 and s_valid=1 held stable; the remaining bits 0,0 follow once s_ready=1; total of 4 beats.
5. Reset mid-word: 4'h9 accepted, 4'h6 held, rst pulsed after 2 bits -> s_valid=0 next cycle, hold discarded; a following 4'h3 serializes as 0,0,1,1.
6. MSB_FIRST=0, p_in=4'b0001 -> s_out=1,0,0,0; s_last on the 4th bit.

Source files
------------

// File: rtl/piso_ser_if.sv
// Handshake bundle between the PIPO stage, the serializer and the serial consumer.
// The master side drives parallel words and serial ready; the slave side is the serializer.
interface piso_ser_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] p_in;
   logic             p_valid;
   logic             p_ready;
   logic             s_out;
   logic             s_valid;
   logic             s_ready;
   logic             s_last;

   modport master (
      output p_in, p_valid, s_ready,
      input  p_ready, s_out, s_valid, s_last
   );

   modport slave (
      input  p_in, p_valid, s_ready,
      output p_ready, s_out, s_valid, s_last
   );
endinterface

// File: rtl/piso_ser.sv
// Parallel-in serial-out serializer with a one-word holding buffer so that
// consecutive words stream out without a bubble.
module piso_ser #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   piso_ser_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             s_out_q, s_out_d;
   logic             s_valid_q, s_valid_d;
   logic             s_last_q, s_last_d;
   logic             p_ready_q, p_ready_d;

   logic             p_xfer;
   logic             s_beat;
   logic             last_beat;
   logic [WIDTH-1:0] sh_shifted;

   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   assign p_xfer    = bus.p_valid && p_ready_q;
   assign s_beat    = s_valid_q && bus.s_ready;
   assign last_beat = s_beat && (cnt_q == LAST_CNT);
   assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

   // Next state; the output flops are fed from the next-state values so
   // they always reflect the post-edge state.
   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;

      case (state_q)
         IDLE: begin
            if (p_xfer) begin
               sh_d    = bus.p_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (s_beat) begin
               if (cnt_q != LAST_CNT) begin
                  sh_d  = sh_shifted;
                  cnt_d = cnt_q + CW'(1);
               end else if (hold_valid_q) begin
                  sh_d         = hold_q;
                  hold_valid_d = 1'b0;
                  cnt_d        = '0;
               end else if (p_xfer) begin
                  sh_d  = bus.p_in;
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            // A word accepted mid-shift parks in hold unless it bypassed straight into sh.
            if (p_xfer && !(last_beat && !hold_valid_q)) begin
               hold_d       = bus.p_in;
               hold_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      s_valid_d = (state_d == SHIFT);
      s_out_d   = s_valid_d && out_bit(sh_d);
      s_last_d  = s_valid_d && (cnt_d == LAST_CNT);
      p_ready_d = (state_d == IDLE) || !hold_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sh_q         <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         s_out_q      <= 1'b0;
         s_valid_q    <= 1'b0;
         s_last_q     <= 1'b0;
         p_ready_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         s_out_q      <= s_out_d;
         s_valid_q    <= s_valid_d;
         s_last_q     <= s_last_d;
         p_ready_q    <= p_ready_d;
      end
   end

   assign bus.s_out   = s_out_q;
   assign bus.s_valid = s_valid_q;
   assign bus.s_last  = s_last_q;
   assign bus.p_ready = p_ready_q;
endmodule
